// File: rtl/core_data_mem.sv
// Single-port byte-addressed data memory with a valid/yumi request handshake.
// Each accepted request runs an accept/respond pair, giving one transaction per two cycles.
module core_data_mem #(
    parameter int unsigned data_mem_addr_width_p = 12
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [35:0]                      port_flat_i,
    input  logic [data_mem_addr_width_p-1:0] addr,
    output logic [33:0]                      port_flat_o
);

    localparam int unsigned IdxWidth = data_mem_addr_width_p - 2;
    localparam int unsigned Words    = 1 << IdxWidth;

    typedef enum logic {StIdle, StResp} state_e;

    state_e      state_r;
    logic [31:0] read_data_r;
    logic [31:0] r_mem [Words];

    logic [31:0]         w_wdata;
    logic                w_valid;
    logic                w_wen;
    logic                w_bnw;
    logic                w_yumi;
    logic [IdxWidth-1:0] w_idx;
    logic [1:0]          w_lane;
    logic [31:0]         w_word;
    logic [7:0]          w_byte;
    logic [31:0]         w_merged;
    logic [31:0]         w_resp_data;
    logic                w_accept;

    assign w_wdata = port_flat_i[35:4];
    assign w_valid = port_flat_i[3];
    assign w_wen   = port_flat_i[2];
    assign w_bnw   = port_flat_i[1];
    assign w_yumi  = port_flat_i[0];
    assign w_idx   = addr[data_mem_addr_width_p-1:2];
    assign w_lane  = addr[1:0];
    assign w_word  = r_mem[w_idx];

    assign w_accept = (state_r == StIdle) && w_valid;

    // Lane select and lane merge, little-endian
    always_comb begin
        w_byte   = w_word[7:0];
        w_merged = w_word;
        unique case (w_lane)
            2'd0: begin
                w_byte         = w_word[7:0];
                w_merged[7:0]  = w_wdata[7:0];
            end
            2'd1: begin
                w_byte         = w_word[15:8];
                w_merged[15:8] = w_wdata[7:0];
            end
            2'd2: begin
                w_byte          = w_word[23:16];
                w_merged[23:16] = w_wdata[7:0];
            end
            default: begin
                w_byte          = w_word[31:24];
                w_merged[31:24] = w_wdata[7:0];
            end
        endcase
    end

    always_comb begin
        w_resp_data = '0;
        if (w_wen) begin
            w_resp_data = w_bnw ? {24'd0, w_wdata[7:0]} : w_wdata;
        end else begin
            w_resp_data = w_bnw ? {24'd0, w_byte} : w_word;
        end
    end

    // Array has no reset: contents survive reset, only the access is suppressed
    always_ff @(posedge clk) begin
        if (reset && w_accept && w_wen) begin
            r_mem[w_idx] <= w_bnw ? w_merged : w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= StIdle;
            read_data_r <= '0;
        end else begin
            case (state_r)
                StIdle: begin
                    if (w_valid) begin
                        read_data_r <= w_resp_data;
                        state_r     <= StResp;
                    end
                end
                default: begin
                    if (w_yumi) begin
                        state_r <= StIdle;
                    end
                end
            endcase
        end
    end

    assign port_flat_o = {read_data_r, (state_r == StResp), w_accept};

endmodule

// File: tb/tb_core_data_mem.sv
// Directed bench for core_data_mem: vector table of single transactions plus
// hand-written backpressure, bulk preload and reset-during-response sequences.
module tb_core_data_mem;

    logic        clk;
    logic        reset;
    logic [35:0] port_flat_i;
    logic [11:0] addr;
    logic [33:0] port_flat_o;

    int n_cmp;
    int n_bad;

    core_data_mem #(
        .data_mem_addr_width_p(12)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .port_flat_i(port_flat_i),
        .addr       (addr),
        .port_flat_o(port_flat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic        bnw;
        logic [11:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Caller is at posedge+1 with the DUT in IDLE; valid/yumi held high throughout.
    task automatic txn(input logic wen, input logic bnw, input logic [11:0] a,
                       input logic [31:0] wd, output logic [31:0] rd);
        port_flat_i = {wd, 1'b1, wen, bnw, 1'b1};
        addr        = a;
        #1;
        chk("accept_yumi", {31'd0, port_flat_o[0]}, 32'd1);
        chk("accept_novalid", {31'd0, port_flat_o[1]}, 32'd0);
        @(posedge clk);
        #1;
        chk("resp_valid", {31'd0, port_flat_o[1]}, 32'd1);
        chk("resp_noyumi", {31'd0, port_flat_o[0]}, 32'd0);
        rd = port_flat_o[33:2];
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs[11];
    logic [31:0] rd;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        vecs[0]  = '{1'b1, 1'b0, 12'h010, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1'b0, 1'b0, 12'h013, 32'h0,        32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b0, 12'h020, 32'h11223344, 32'h11223344};
        vecs[4]  = '{1'b1, 1'b1, 12'h022, 32'h000000AA, 32'h000000AA};
        vecs[5]  = '{1'b0, 1'b0, 12'h020, 32'h0,        32'h11AA3344};
        vecs[6]  = '{1'b0, 1'b1, 12'h023, 32'h0,        32'h00000011};
        vecs[7]  = '{1'b0, 1'b1, 12'h021, 32'h0,        32'h00000033};
        vecs[8]  = '{1'b1, 1'b1, 12'h020, 32'hFFFFFF55, 32'h00000055};
        vecs[9]  = '{1'b0, 1'b0, 12'h020, 32'h0,        32'h11AA3355};
        vecs[10] = '{1'b0, 1'b1, 12'h022, 32'h0,        32'h000000AA};

        // Reset
        reset       = 1'b0;
        port_flat_i = '0;
        addr        = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, port_flat_o[1]}, 32'd0);
        chk("rst_rdata", port_flat_o[33:2], 32'd0);
        chk("rst_yumi_lo", {31'd0, port_flat_o[0]}, 32'd0);
        port_flat_i[3] = 1'b1;
        #1;
        chk("rst_yumi_hi", {31'd0, port_flat_o[0]}, 32'd1);
        @(posedge clk);
        #1;
        chk("rst_still_idle", {31'd0, port_flat_o[1]}, 32'd0);
        port_flat_i = '0;
        reset       = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_no_req", {31'd0, port_flat_o[1]}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            txn(vecs[i].wen, vecs[i].bnw, vecs[i].a, vecs[i].wd, rd);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        end

        // Backpressure: load held in RESP, competing store must be ignored
        port_flat_i = {32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        addr        = 12'h010;
        #1;
        chk("bp_accept", {31'd0, port_flat_o[0]}, 32'd1);
        @(posedge clk);
        #1;
        port_flat_i = {32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 1'b0};
        addr        = 12'h014;
        for (int c = 0; c < 3; c++) begin
            chk("bp_valid", {31'd0, port_flat_o[1]}, 32'd1);
            chk("bp_noaccept", {31'd0, port_flat_o[0]}, 32'd0);
            chk("bp_rdata", port_flat_o[33:2], 32'hDEADBEEF);
            @(posedge clk);
            #1;
        end
        port_flat_i = {32'h0, 1'b0, 1'b0, 1'b0, 1'b1};
        @(posedge clk);
        #1;
        chk("bp_release_idle", {31'd0, port_flat_o[1]}, 32'd0);
        port_flat_i = '0;
        txn(1'b0, 1'b0, 12'h014, 32'h0, rd);
        chk("bp_no_write", (rd == 32'hCAFEF00D) ? 32'd1 : 32'd0, 32'd0);

        // Bulk preload, then read back
        for (int i = 0; i < 1024; i++) begin
            txn(1'b1, 1'b0, 12'(i * 4), 32'(i), rd);
        end
        for (int i = 0; i < 1024; i++) begin
            txn(1'b0, 1'b0, 12'(i * 4), 32'h0, rd);
            chk($sformatf("bulk_rd%0d", i), rd, 32'(i));
        end
        txn(1'b0, 1'b0, 12'hFFC, 32'h0, rd);
        chk("bulk_top_word", rd, 32'd1023);

        // Reset during RESP after a store
        port_flat_i = {32'h5, 1'b1, 1'b1, 1'b0, 1'b0};
        addr        = 12'h040;
        @(posedge clk);
        #1;
        chk("rr_resp_valid", {31'd0, port_flat_o[1]}, 32'd1);
        reset       = 1'b0;
        port_flat_i = '0;
        @(posedge clk);
        #1;
        chk("rr_valid_cleared", {31'd0, port_flat_o[1]}, 32'd0);
        chk("rr_rdata_cleared", port_flat_o[33:2], 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        txn(1'b0, 1'b0, 12'h040, 32'h0, rd);
        chk("rr_store_kept", rd, 32'h5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
